// File: rtl/btb_predictor.sv
// IF-stage branch target buffer: direct-mapped table with 2-bit direction counters,
// combinational lookup on the fetch PC, registered update from ID-stage resolution.
module btb_predictor #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] next_pc_pred,
    output logic                 pred_taken,
    output logic                 pred_hit,
    input  logic                 update_valid,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_taken,
    input  logic                 update_uncond,
    input  logic                 update_mispredict,
    output logic [15:0]          mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [WORD_SIZE-1:0] target;
        logic                 uncond;
        logic [1:0]           cnt;
    } entry_t;

    localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, uncond: 1'b0, cnt: 2'b01};

    entry_t btb_q [ENTRIES];

    // Lookup reads only registered state, so a same-cycle update is not visible here.
    entry_t rd;
    always_comb begin
        rd           = btb_q[pc[INDEX_BITS-1:0]];
        pred_hit     = rd.valid && (rd.tag == pc[WORD_SIZE-1:INDEX_BITS]);
        pred_taken   = pred_hit && (rd.uncond || rd.cnt[1]);
        next_pc_pred = pred_taken ? rd.target : pc + WORD_SIZE'(1);
    end

    logic [INDEX_BITS-1:0] upd_idx;
    entry_t                upd_old;
    entry_t                upd_new;
    logic                  upd_hit;
    logic                  wr_en;

    always_comb begin
        upd_idx = update_pc[INDEX_BITS-1:0];
        upd_old = btb_q[upd_idx];
        upd_hit = upd_old.valid && (upd_old.tag == update_pc[WORD_SIZE-1:INDEX_BITS]);
        upd_new = upd_old;
        wr_en   = 1'b0;
        if (update_valid) begin
            if (upd_hit) begin
                wr_en          = 1'b1;
                upd_new.target = update_target;
                if (update_uncond)
                    upd_new.cnt = 2'b11;
                else if (update_taken && upd_old.cnt != 2'b11)
                    upd_new.cnt = upd_old.cnt + 2'b01;
                else if (!update_taken && upd_old.cnt != 2'b00)
                    upd_new.cnt = upd_old.cnt - 2'b01;
            end else if (update_taken) begin
                // Only taken outcomes earn an entry; not-taken misses leave the table alone.
                wr_en          = 1'b1;
                upd_new.valid  = 1'b1;
                upd_new.tag    = update_pc[WORD_SIZE-1:INDEX_BITS];
                upd_new.target = update_target;
                upd_new.uncond = update_uncond;
                upd_new.cnt    = update_uncond ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++)
                btb_q[i] <= RST_ENTRY;
            mispredict_count <= '0;
        end else begin
            if (wr_en)
                btb_q[upd_idx] <= upd_new;
            if (update_valid && update_mispredict && mispredict_count != 16'hFFFF)
                mispredict_count <= mispredict_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: directed steps push hand-computed lookups,
// a negedge monitor pops and compares whenever a check is presented.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pc = '0;
    logic [15:0] next_pc_pred;
    logic        pred_taken;
    logic        pred_hit;
    logic        update_valid = 1'b0;
    logic [15:0] update_pc = '0;
    logic [15:0] update_target = '0;
    logic        update_taken = 1'b0;
    logic        update_uncond = 1'b0;
    logic        update_mispredict = 1'b0;
    logic [15:0] mispredict_count;

    btb_predictor #(.WORD_SIZE(16), .INDEX_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc),
        .next_pc_pred(next_pc_pred), .pred_taken(pred_taken), .pred_hit(pred_hit),
        .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .update_uncond(update_uncond),
        .update_mispredict(update_mispredict), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [15:0] npc;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic chk_en = 1'b0;
    int   chk_id = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic cmp(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s check %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard: check presented with empty queue");
            end else begin
                mon_e = exp_q.pop_front();
                cmp("pred_hit", mon_e.id, {15'd0, pred_hit}, {15'd0, mon_e.hit});
                cmp("pred_taken", mon_e.id, {15'd0, pred_taken}, {15'd0, mon_e.taken});
                cmp("next_pc_pred", mon_e.id, next_pc_pred, mon_e.npc);
                cmp("mispredict_count", mon_e.id, mispredict_count, mon_e.cnt);
            end
        end
    end

    task automatic drive(input logic rst, input logic [15:0] p, input logic uv,
                         input logic [15:0] upc, input logic [15:0] utgt,
                         input logic ut, input logic uu, input logic um);
        @(posedge clk);
        #1;
        reset_n = rst; pc = p; update_valid = uv; update_pc = upc;
        update_target = utgt; update_taken = ut; update_uncond = uu;
        update_mispredict = um; chk_en = 1'b0;
    endtask

    task automatic drive_chk(input logic rst, input logic [15:0] p, input logic uv,
                             input logic [15:0] upc, input logic [15:0] utgt,
                             input logic ut, input logic uu, input logic um,
                             input logic eh, input logic et,
                             input logic [15:0] enpc, input logic [15:0] ecnt);
        drive(rst, p, uv, upc, utgt, ut, uu, um);
        exp_q.push_back('{eh, et, enpc, ecnt, chk_id});
        chk_id++;
        chk_en = 1'b1;
    endtask

    initial begin
        drive(0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
        drive(0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
        // reset state; allocate conditional taken branch at 0x12 (cnt 10)
        drive_chk(1, 16'h0010, 1, 16'h0012, 16'h0020, 1, 0, 0, 0, 0, 16'h0011, 16'h0000);
        // cnt 10 -> taken; NT update -> 01
        drive_chk(1, 16'h0012, 1, 16'h0012, 16'h0020, 0, 0, 0, 1, 1, 16'h0020, 16'h0000);
        // cnt 01; NT -> 00
        drive_chk(1, 16'h0012, 1, 16'h0012, 16'h0020, 0, 0, 0, 1, 0, 16'h0013, 16'h0000);
        // cnt 00; taken x3: 01, 10, 11
        drive_chk(1, 16'h0012, 1, 16'h0012, 16'h0020, 1, 0, 0, 1, 0, 16'h0013, 16'h0000);
        drive_chk(1, 16'h0012, 1, 16'h0012, 16'h0020, 1, 0, 0, 1, 0, 16'h0013, 16'h0000);
        drive_chk(1, 16'h0012, 1, 16'h0012, 16'h0020, 1, 0, 0, 1, 1, 16'h0020, 16'h0000);
        // cnt 11; NT -> 10
        drive_chk(1, 16'h0012, 1, 16'h0012, 16'h0020, 0, 0, 0, 1, 1, 16'h0020, 16'h0000);
        // cnt 10 still taken; NT -> 01
        drive_chk(1, 16'h0012, 1, 16'h0012, 16'h0020, 0, 0, 0, 1, 1, 16'h0020, 16'h0000);
        // cnt 01 not taken; JMP 0x05 -> 0x100 allocated with a mispredict
        drive_chk(1, 16'h0012, 1, 16'h0005, 16'h0100, 1, 1, 1, 1, 0, 16'h0013, 16'h0000);
        // JMP hit; re-update not-taken uncond keeps it taken
        drive_chk(1, 16'h0005, 1, 16'h0005, 16'h0100, 0, 1, 0, 1, 1, 16'h0100, 16'h0001);
        drive_chk(1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 16'h0001);
        // aliasing tag at same index; not-taken miss at 0x30 allocates nothing
        drive_chk(1, 16'h0015, 1, 16'h0030, 16'h0044, 0, 0, 0, 0, 0, 16'h0016, 16'h0001);
        // same-cycle lookup/update at 0x30: lookup sees pre-update table
        drive_chk(1, 16'h0030, 1, 16'h0030, 16'h0044, 1, 0, 0, 0, 0, 16'h0031, 16'h0001);
        // inert update fields with update_valid=0 must not change anything
        drive_chk(1, 16'h0030, 0, 16'h0030, 16'h0999, 1, 1, 1, 1, 1, 16'h0044, 16'h0001);
        drive_chk(1, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h0044, 16'h0001);
        // mispredict counter saturation
        for (int i = 0; i < 65536; i++)
            drive(1, 16'h0000, 1, 16'h0040, 16'h0000, 0, 0, 1);
        drive_chk(1, 16'h0012, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0013, 16'hFFFF);
        drive_chk(1, 16'h0012, 1, 16'h0040, 16'h0000, 0, 0, 1, 1, 0, 16'h0013, 16'hFFFF);
        // reset with concurrent taken update: update dropped, learned state gone
        drive(0, 16'h0000, 1, 16'h0050, 16'h0060, 1, 1, 1);
        drive_chk(1, 16'h0050, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0051, 16'h0000);
        drive_chk(1, 16'h0012, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0013, 16'h0000);
        drive_chk(1, 16'h0005, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0006, 16'h0000);
        drive_chk(1, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        drive(1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- IF-stage branch target buffer with 2-bit saturating direction counters.
- Each cycle it supplies the predicted next PC for the fetch PC.
- ID-stage target computation for BNE/BEQ/BGZ/BLZ/JMP/JAL resolves each branch and writes the outcome back through the update port.
- JPR/JRL are never allocated; they stay resolved in EX.

Parameters:
WORD_SIZE, 16, instruction address/data width (matches `WORD_SIZE in opcodes.v)
INDEX_BITS, 4, log2 of entry count (16 entries, direct-mapped)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
pc  input  WORD_SIZE  current IF fetch address
next_pc_pred  output  WORD_SIZE  predicted fetch address for next cycle
pred_taken  output  1  1 when next_pc_pred is a BTB target
pred_hit  output  1  1 when pc matches a valid entry
update_valid  input  1  ID resolution strobe, one per resolved branch/jump
update_pc  input  WORD_SIZE  address of resolved instruction
update_target  input  WORD_SIZE  resolved target (PC+1+offset or jump target)
update_taken  input  1  actual direction
update_uncond  input  1  1 for JMP/JAL; 0 for conditional branches
update_mispredict  input  1  ID detected IF prediction was wrong
mispredict_count  output  16  saturating count of mispredicts

Behaviour:
- Entry fields: valid, tag = pc[WORD_SIZE-1:INDEX_BITS], target, uncond flag, cnt[1:0].
- Index is pc[INDEX_BITS-1:0].
- Lookup is combinational from registered table state, with zero-cycle latency.
  - hit = valid && tag match.
  - pred_taken = hit && (uncond || cnt[1]).
  - next_pc_pred = pred_taken ? target : pc+1.
  - pc+1 wraps modulo 2^WORD_SIZE, so 0xFFFF goes to 0x0000.
- Update is registered and takes effect on the edge where update_valid=1. It is visible to lookups from the next cycle.
- Update on a hit (same index, tag matches):
  - target <= update_target.
  - If uncond: cnt <= 11.
  - Otherwise cnt increments on taken and decrements on not-taken, saturating at 11 and 00.
- Update on a miss (invalid entry or tag mismatch):
  - Allocates or replaces only if update_taken=1. Sets valid=1, new tag, target, uncond <= update_uncond, cnt <= uncond ? 11 : 10.
  - If update_taken=0, the table is unchanged.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (read-before-write, no bypass).
- mispredict_count increments when update_valid && update_mispredict, saturating at 0xFFFF. update_mispredict is ignored when update_valid=0.
- Reset when reset_n=0 at a rising edge:
  - All valid bits cleared, all cnt <= 01, targets/tags <= 0, mispredict_count <= 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, next_pc_pred=pc+1.
  - Reset dominates a concurrent update_valid; that update is dropped.
  - Reset mid-stream discards all learned state.
- Inputs are assumed stable around the edge. X on update_* while update_valid=0 must not alter state.
- No FSM beyond per-entry counters. Each counter follows 00 SNT <-> 01 WNT <-> 10 WT <-> 11 ST.
- Typical size: about 150–250 lines of RTL.

Test Plan:
- Reset then pc=0x0010 -> pred_hit=0, pred_taken=0, next_pc_pred=0x0011, mispredict_count=0.
- Update {pc=0x0012, target=0x0020, taken=1, uncond=0}; next cycle pc=0x0012 -> hit=1, taken=1, next_pc_pred=0x0020. Two not-taken updates then -> taken=0, next_pc_pred=0x0013.
- Counter saturation: three taken updates on the 0x0012 entry, then one not-taken -> still predicts taken (cnt 11->10). A second not-taken -> predicts not taken (cnt 01).
- Uncond JMP at 0x0005 to 0x0100; then update same pc with taken=0, uncond=1 -> always taken, next_pc_pred=0x0100. Aliasing pc 0x0015 (same index, different tag) -> hit=0, next_pc_pred=0x0016.
- Not-taken miss update at pc=0x0030 -> no allocation, next lookup hit=0. Same-cycle update and lookup at pc=0x0030 with taken=1 -> that cycle hit=0; following cycle hit=1.
- Drive update_valid=1 with update_mispredict=1 for 0x10000 cycles -> mispredict_count saturates at 0xFFFF. Assert reset_n=0 with update_valid=1 -> count=0, no entry allocated. pc=0xFFFF with empty table -> next_pc_pred=0x0000.
